cpu_lr_stack: RTL
=================

// Module: cpu_lr_stack
// PURPOSE
//   Parametrised hardware loop-register stack for the one-cycle CPU, used for nested counted loops.
//   Holds up to DEPTH loop counts of WIDTH bits. The top entry is the active loop.
//   A loop-end instruction decrements the top entry and reports whether to branch back.
//   An exhausted entry pops automatically. Sits beside the PC unit; LR_TAKEN feeds the PC mux.
// PARAMETERS
//   WIDTH  8  bit width of each loop count
//   DEPTH  4  maximum nesting depth (>=2)
//   LVL_W  $clog2(DEPTH+1)  localparam, width of LR_LEVEL
// PORTS
//   CLK         in   1          system clock, rising edge
//   RST         in   1          asynchronous, active-high reset
//   LR_LD       in   1          push LR_DATA as a new top entry
//   LR_DATA     in   WIDTH      loop count to push
//   LR_DEC      in   1          loop-end: decrement/test top entry
//   LR_POP      in   1          discard top entry (loop break)
//   LR_ERR_CLR  in   1          clear sticky LR_ERR
//   LR_OUT      out  WIDTH      current top count; 0 when empty
//   LR_TAKEN    out  1          combinational: branch back this cycle
//   LR_EMPTY    out  1          no entries
//   LR_FULL     out  1          DEPTH entries held
//   LR_LEVEL    out  LVL_W      number of entries held
//   LR_ERR      out  1          sticky overflow/underflow flag
// BEHAVIOUR
//   - Reset (async, RST=1): level=0, all entries=0, LR_ERR=0.
//     Outputs while in reset: LR_OUT=0, LR_TAKEN=0, LR_EMPTY=1, LR_FULL=0, LR_LEVEL=0.
//   - State is level plus the entry array. There is no other FSM. All updates happen on the rising CLK edge.
//   - Operation priority: LR_LD > LR_DEC > LR_POP. Only the highest asserted operation executes.
//     Lower-priority requests in the same cycle are dropped silently and do not set LR_ERR.
//   - LR_LD, not full: entry[level] <= LR_DATA; level+1. LR_OUT shows the new value next cycle.
//     LR_LD while full: no change; LR_ERR <= 1.
//   - LR_DEC, not empty, top > 1: top <= top-1; LR_TAKEN=1 in the same cycle (combinational).
//   - LR_DEC, not empty, top <= 1: pop (level-1); LR_TAKEN=0.
//     A count of 0 behaves as 1, so the loop body runs once.
//   - LR_DEC while empty: no change; LR_TAKEN=0; LR_ERR <= 1.
//   - LR_POP, not empty: level-1. LR_POP while empty: no change; LR_ERR <= 1.
//   - LR_ERR_CLR clears LR_ERR. If an error occurs in the same cycle, the set wins.
//   - Decrement is modulo-free: it never wraps below 0, because top<=1 pops instead.
//   - LR_OUT, LR_EMPTY, LR_FULL and LR_LEVEL are decoded combinationally from registered state.
//     Latency from an operation to these outputs is 1 cycle.
//   - Popped entries keep stale data but are never visible on LR_OUT.
//   - RST asserted mid-loop: immediate return to the reset state. The next push starts at level 0.
// STRUCTURE
//   - Shared header cpu_defs.vh: default LR_WIDTH and LR_DEPTH, and the loop-op encodings used by the decoder.
//   - Sub-module cpu_lr_entry: one WIDTH-bit register with async reset, load enable and
//     decrement enable. Instanced DEPTH times via generate.
//   - Top level holds the level counter, the priority/op decode, the error flag and the top-of-stack mux.
// TESTING  (WIDTH=8, DEPTH=4)
//   - Reset then idle.
//     Expect LR_OUT=0, LR_EMPTY=1, LR_LEVEL=0, LR_ERR=0.
//   - Push 8'h03, then LR_DEC x3.
//     Expect LR_TAKEN=1,1,0 and LR_OUT=03,02,01, then 00 with LR_EMPTY=1.
//   - Nesting: push 02, push 05, LR_DEC x5.
//     Expect LR_TAKEN=1,1,1,1,0. After the 5th dec: LR_LEVEL=1, LR_OUT=02.
//   - Overflow: push A7,13,01,FF (LR_FULL=1), then push 44.
//     Expect level stays 4, LR_OUT=FF, LR_ERR=1. LR_ERR_CLR -> LR_ERR=0.
//   - Underflow and priority:
//     LR_DEC on empty -> LR_ERR=1, LR_TAKEN=0.
//     LR_LD=1 with LR_DEC=1 and data 09 -> push only, LR_OUT=09.
//   - Async reset mid-loop: push 05, dec once, assert RST between edges.
//     Expect outputs at reset values immediately. A push of 0 then LR_DEC gives LR_TAKEN=0 and empty.

Source files
------------

// File: rtl/cpu_lr_stack_pkg.sv
// Shared definitions for the loop-register stack: default geometry and the
// loop-op encoding produced by the priority decode.
package cpu_lr_stack_pkg;

  localparam int LR_WIDTH = 8;
  localparam int LR_DEPTH = 4;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_LD   = 2'd1,
    OP_DEC  = 2'd2,
    OP_POP  = 2'd3
  } lr_op_e;

  // Load beats decrement beats pop; lower requests in the same cycle vanish.
  function automatic lr_op_e decode_op(input logic ld, input logic dec, input logic pop);
    if (ld)       return OP_LD;
    else if (dec) return OP_DEC;
    else if (pop) return OP_POP;
    else          return OP_NONE;
  endfunction

endpackage

// File: rtl/cpu_lr_stack_entry.sv
// One loop-count register of the stack with load and decrement enables.
module cpu_lr_stack_entry #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ld_en,
  input  logic             dec_en,
  input  logic [WIDTH-1:0] ld_data,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         q <= '0;
    else if (ld_en)  q <= ld_data;
    else if (dec_en) q <= q - WIDTH'(1);
  end

endmodule

// File: rtl/cpu_lr_stack.sv
// Hardware loop-register stack for nested counted loops; LR_TAKEN steers the
// PC mux back to the loop start while the active count is still above one.
module cpu_lr_stack
  import cpu_lr_stack_pkg::*;
#(
  parameter int WIDTH = LR_WIDTH,
  parameter int DEPTH = LR_DEPTH,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LR_LD,
  input  logic [WIDTH-1:0] LR_DATA,
  input  logic             LR_DEC,
  input  logic             LR_POP,
  input  logic             LR_ERR_CLR,
  output logic [WIDTH-1:0] LR_OUT,
  output logic             LR_TAKEN,
  output logic             LR_EMPTY,
  output logic             LR_FULL,
  output logic [LVL_W-1:0] LR_LEVEL,
  output logic             LR_ERR
);

  logic [LVL_W-1:0] level;
  logic [WIDTH-1:0] entry_q [DEPTH];
  logic [DEPTH-1:0] ld_en;
  logic [DEPTH-1:0] dec_en;
  logic [WIDTH-1:0] top_val;
  logic             empty;
  logic             full;
  logic             err_set;
  lr_op_e           op;

  assign op    = decode_op(LR_LD, LR_DEC, LR_POP);
  assign empty = (level == '0);
  assign full  = (level == LVL_W'(DEPTH));

  // Top of stack lives at index level-1; an empty stack reads as zero.
  always_comb begin
    top_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (level == LVL_W'(i + 1)) top_val = entry_q[i];
    end
  end

  // Counts of 0 and 1 both end the loop, so only values above 1 decrement.
  always_comb begin
    LR_TAKEN = (op == OP_DEC) && !empty && (top_val > WIDTH'(1));
    err_set  = ((op == OP_LD)  && full)  ||
               ((op == OP_DEC) && empty) ||
               ((op == OP_POP) && empty);
    for (int i = 0; i < DEPTH; i++) begin
      ld_en[i]  = (op == OP_LD) && !full && (level == LVL_W'(i));
      dec_en[i] = LR_TAKEN && (level == LVL_W'(i + 1));
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    cpu_lr_stack_entry #(.WIDTH(WIDTH)) u_entry (
      .CLK     (CLK),
      .RST     (RST),
      .ld_en   (ld_en[g]),
      .dec_en  (dec_en[g]),
      .ld_data (LR_DATA),
      .q       (entry_q[g])
    );
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      level <= '0;
    end else begin
      unique case (op)
        OP_LD:   if (!full) level <= level + LVL_W'(1);
        OP_DEC:  if (!empty && !LR_TAKEN) level <= level - LVL_W'(1);
        OP_POP:  if (!empty) level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // A fresh error outranks a simultaneous clear so no fault is lost.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)             LR_ERR <= 1'b0;
    else if (err_set)    LR_ERR <= 1'b1;
    else if (LR_ERR_CLR) LR_ERR <= 1'b0;
  end

  assign LR_OUT   = top_val;
  assign LR_EMPTY = empty;
  assign LR_FULL  = full;
  assign LR_LEVEL = level;

endmodule
